// File: rtl/crossy_robbers_usb_pkg.sv
// Shared definitions for the MAX3421E INT/GPX interrupt controller:
// register addresses, EVENT bit positions, INT FSM state type, counter width.
package crossy_robbers_usb_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EVENT  = 2'd2;
  localparam logic [1:0] ADDR_TMO    = 2'd3;

  localparam int EV_INT = 0;
  localparam int EV_GPX = 1;
  localparam int EV_TMO = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_STUCK = 2'd2
  } int_state_e;

endpackage

// File: rtl/crossy_robbers_usb_irq_ctrl_if.sv
// Avalon-MM slave bus plus IRQ line between the Nios II and the USB
// interrupt controller.
//   address/chipselect/write_n/writedata : CPU -> controller
//   readdata (1-cycle latency), irq      : controller -> CPU
interface crossy_robbers_usb_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/crossy_robbers_sync_edge.sv
// 2-FF synchronizer for an asynchronous pin plus a one-cycle rising-edge pulse.
//   pin_i  : raw asynchronous input
//   lvl_o  : synchronized level
//   rise_o : high for one cycle after lvl_o goes 0 -> 1
// All flops reset to RST_VAL so no edge is seen out of reset at the idle level.
module crossy_robbers_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o
);

  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], pin_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_q <= {3{RST_VAL}};
    else       sh_q <= sh_d;
  end

  assign lvl_o  = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/crossy_robbers_usb_irq_ctrl.sv
// MAX3421E INT/GPX interrupt controller, Avalon-MM slave with one IRQ.
//   clk, reset        : system clock, async active-high reset
//   bus (slave)       : register access, readdata, irq
//   usb_int, usb_gpx  : raw asynchronous pins from the MAX3421E
//
// INT FSM:
//   state | meaning
//   IDLE  | no unserviced INT
//   PEND  | INT captured, watchdog counting
//   STUCK | watchdog expired, counter held until software clears EVENT[0]
module crossy_robbers_usb_irq_ctrl
  import crossy_robbers_usb_pkg::*;
#(
  parameter logic [15:0] TMO_RESET      = 16'hFFFF,
  parameter bit          INT_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  crossy_robbers_usb_irq_ctrl_if.slave  bus,
  input  logic                          usb_int,
  input  logic                          usb_gpx
);

  logic int_pin, int_lvl, int_rise, gpx_lvl, gpx_rise;

  // Normalize INT to active-high before synchronizing; a single inverter
  // ahead of the first flop cannot glitch.
  assign int_pin = INT_ACTIVE_LOW ? ~usb_int : usb_int;

  crossy_robbers_sync_edge #(.RST_VAL(1'b0)) u_sync_int (
    .clk(clk), .reset(reset), .pin_i(int_pin), .lvl_o(int_lvl), .rise_o(int_rise));

  crossy_robbers_sync_edge #(.RST_VAL(1'b0)) u_sync_gpx (
    .clk(clk), .reset(reset), .pin_i(usb_gpx), .lvl_o(gpx_lvl), .rise_o(gpx_rise));

  int_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             retrig_q, retrig_d;
  logic [2:0]       event_q, event_d, ev_set, ev_clr;
  logic [2:0]       mask_q, mask_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [31:0]      readdata_q, readdata_d, rd_mux;
  logic             irq_q, irq_d;
  logic [1:0]       state_bits;
  logic             wr_en, unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign ev_clr       = (wr_en && bus.address == ADDR_EVENT) ? bus.writedata[2:0] : 3'b000;
  assign state_bits   = state_q;
  assign unused_wdata = ^bus.writedata[31:16];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retrig_d = 1'b0;
    ev_set   = 3'b000;
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (int_rise) begin
          ev_set[EV_INT] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_PEND;
        end
      end
      ST_PEND, ST_STUCK: begin
        // A software clear outranks a timeout in the same cycle.
        if (ev_clr[EV_INT]) begin
          cnt_d = '0;
          if (int_lvl) begin
            // Level still asserted: re-raise EVENT[0] on the next cycle.
            state_d  = ST_PEND;
            retrig_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_PEND) begin
          cnt_d = cnt_inc;
          if (tmo_q != 16'd0 && cnt_inc == tmo_q) begin
            ev_set[EV_TMO] = 1'b1;
            state_d        = ST_STUCK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retrig_q) ev_set[EV_INT] = 1'b1;
    ev_set[EV_GPX] = gpx_rise;

    // Set wins over a same-cycle write-1-to-clear.
    event_d = (event_q & ~ev_clr) | ev_set;

    mask_d = mask_q;
    tmo_d  = tmo_q;
    if (wr_en && bus.address == ADDR_MASK) mask_d = bus.writedata[2:0];
    if (wr_en && bus.address == ADDR_TMO)  tmo_d  = bus.writedata[15:0];

    case (bus.address)
      ADDR_STATUS: rd_mux = {28'd0, state_bits, gpx_lvl, int_lvl};
      ADDR_MASK:   rd_mux = {29'd0, mask_q};
      ADDR_EVENT:  rd_mux = {29'd0, event_q};
      default:     rd_mux = {16'd0, tmo_q};
    endcase
    readdata_d = bus.chipselect ? rd_mux : readdata_q;

    irq_d = |(event_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retrig_q   <= 1'b0;
      event_q    <= 3'b000;
      mask_q     <= 3'b000;
      tmo_q      <= TMO_RESET;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retrig_q   <= retrig_d;
      event_q    <= event_d;
      mask_q     <= mask_d;
      tmo_q      <= tmo_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_crossy_robbers_usb_irq_ctrl.sv
module tb_crossy_robbers_usb_irq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic usb_int = 1'b1;
  logic usb_gpx = 1'b0;

  crossy_robbers_usb_irq_ctrl_if bus();

  crossy_robbers_usb_irq_ctrl #(.TMO_RESET(16'hFFFF), .INT_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .usb_int(usb_int), .usb_gpx(usb_gpx));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // INT watchdog modelled by timestamp: elapsed cycles since the last reload.
  int         m_state;     // 0 idle, 1 pending, 2 stuck
  int         m_since;
  int         cyc;
  bit         m_retrig;
  bit [2:0]   m_ev, m_mask;
  bit [15:0]  m_tmo;
  bit         m_irq;
  bit [31:0]  m_rd;
  bit [2:0]   ih, gh;      // pin delay lines: [1] = synchronized level, [2] = previous

  task automatic model_reset();
    m_state = 0; m_since = 0; cyc = 0; m_retrig = 0;
    m_ev = 0; m_mask = 0; m_tmo = 16'hFFFF; m_irq = 0; m_rd = 0;
    ih = 0; gh = 0;
  endtask

  task automatic model_step();
    bit ilvl, irise, glvl, grise, wr, nxt_retrig;
    bit [2:0] clr, set;
    int elapsed;
    if (reset) begin model_reset(); return; end
    cyc++;
    ilvl = ih[1]; irise = ih[1] && !ih[2];
    glvl = gh[1]; grise = gh[1] && !gh[2];
    wr   = bus.chipselect && !bus.write_n;
    clr  = (wr && bus.address == 2'd2) ? bus.writedata[2:0] : 3'b0;
    set  = 0;
    nxt_retrig = 0;
    if (bus.chipselect) begin
      case (bus.address)
        2'd0: m_rd = {28'd0, 2'(m_state), glvl, ilvl};
        2'd1: m_rd = {29'd0, m_mask};
        2'd2: m_rd = {29'd0, m_ev};
        default: m_rd = {16'd0, m_tmo};
      endcase
    end
    m_irq = |(m_ev & m_mask);
    if (m_state == 0) begin
      if (irise) begin set[0] = 1; m_since = cyc; m_state = 1; end
    end else if (clr[0]) begin
      m_since = cyc;
      if (ilvl) begin m_state = 1; nxt_retrig = 1; end
      else m_state = 0;
    end else if (m_state == 1) begin
      elapsed = cyc - m_since;
      if (elapsed > 65535) elapsed = 65535;
      if (m_tmo != 0 && elapsed == int'(m_tmo)) begin set[2] = 1; m_state = 2; end
    end
    if (m_retrig) set[0] = 1;
    m_retrig = nxt_retrig;
    if (grise) set[1] = 1;
    m_ev = (m_ev & ~clr) | set;
    if (wr && bus.address == 2'd1) m_mask = bus.writedata[2:0];
    if (wr && bus.address == 2'd3) m_tmo  = bus.writedata[15:0];
    ih = {ih[1:0], ~usb_int};
    gh = {gh[1:0], usb_gpx};
  endtask

  // Compare process: model advances on each edge, DUT outputs checked 1 time unit later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("readdata", bus.readdata, m_rd);
    chk("irq", {31'd0, bus.irq}, {31'd0, m_irq});
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    d = bus.readdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd;
    bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    bus_read(2'd0, rd); chk("rst_status", rd, 32'h0);
    bus_read(2'd1, rd); chk("rst_mask", rd, 32'h0);
    bus_read(2'd2, rd); chk("rst_event", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_tmo", rd, 32'hFFFF);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);

    // GPX edge -> EVENT[1] three clocks later, irq one more
    bus_write(2'd1, 32'h2);
    @(negedge clk); usb_gpx = 1'b1;
    repeat (3) @(negedge clk);
    chk("gpx_irq_not_yet", {31'd0, bus.irq}, 32'h0);
    @(negedge clk);
    chk("gpx_irq_set", {31'd0, bus.irq}, 32'h1);
    @(negedge clk); usb_gpx = 1'b0;
    bus_read(2'd2, rd); chk("gpx_event", rd, 32'h2);
    bus_write(2'd2, 32'h2);
    @(negedge clk);
    chk("gpx_irq_clr", {31'd0, bus.irq}, 32'h0);
    bus_read(2'd2, rd); chk("gpx_event_clr", rd, 32'h0);

    // INT watchdog: TMO=10, continuous EVENT read to pin the timing
    bus_write(2'd3, 32'd10);
    bus_write(2'd1, 32'h5);
    @(negedge clk);
    usb_int = 1'b0;
    bus.address = 2'd2; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3)  chk("int_ev_k3", bus.readdata, 32'h0);
      if (k == 4)  chk("int_ev_k4", bus.readdata, 32'h1);
      if (k == 13) chk("int_ev_k13", bus.readdata, 32'h1);
      if (k == 14) chk("int_ev_k14", bus.readdata, 32'h5);
    end
    bus.chipselect = 1'b0;
    bus_read(2'd0, rd); chk("stuck_status", rd, 32'h9);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); chk("retrig_event", rd, 32'h5);
    bus_read(2'd0, rd); chk("retrig_status", rd, 32'h5);
    @(negedge clk); usb_int = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(2'd2, 32'h5);
    bus_read(2'd0, rd); chk("idle_status", rd, 32'h0);
    bus_read(2'd2, rd); chk("idle_event", rd, 32'h0);

    // Same-cycle GPX set and W1C clear: set wins
    @(negedge clk); usb_gpx = 1'b1;
    repeat (4) @(negedge clk); usb_gpx = 1'b0;
    repeat (3) @(negedge clk);
    usb_gpx = 1'b1;                     // n0
    @(negedge clk);                     // n1
    @(negedge clk);                     // n2: write lands on the capture edge
    bus.address = 2'd2; bus.writedata = 32'h2; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus_read(2'd2, rd); chk("set_wins", rd, 32'h2);
    @(negedge clk); usb_gpx = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin @(negedge clk); usb_int = ~usb_int; end
      else if (r < 4) begin @(negedge clk); usb_gpx = ~usb_gpx; end
      else if (r < 6) bus_read(2'($urandom_range(0, 3)), rd);
      else if (r < 9) begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        bus_write(a, (a == 2'd3) ? 32'($urandom_range(0, 24)) : $urandom);
      end
      else @(negedge clk);
    end
    @(negedge clk); usb_int = 1'b1; usb_gpx = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(2'd2, 32'h7);

    // TMO=0: no timeout over 70000 cycles; then TMO=FFFF hits the saturated count
    bus_write(2'd1, 32'h4);
    bus_write(2'd3, 32'h0);
    @(negedge clk); usb_int = 1'b0;
    repeat (70000) @(negedge clk);
    bus_read(2'd2, rd); chk("tmo0_event", rd, 32'h1);
    chk("tmo0_irq", {31'd0, bus.irq}, 32'h0);
    bus_write(2'd3, 32'hFFFF);
    bus_read(2'd2, rd); chk("sat_event", rd, 32'h5);
    chk("sat_irq", {31'd0, bus.irq}, 32'h1);

    // Async reset in STUCK with irq high
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, bus.irq}, 32'h0);
    chk("async_rst_rd", bus.readdata, 32'h0);
    usb_int = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(2'd0, rd); chk("rst2_status", rd, 32'h0);
    bus_read(2'd1, rd); chk("rst2_mask", rd, 32'h0);
    bus_read(2'd2, rd); chk("rst2_event", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst2_tmo", rd, 32'hFFFF);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crossy_robbers_usb_irq_ctrl.md
# crossy_robbers_usb_irq_ctrl

Interrupt/event controller for the MAX3421E USB host chip's INT and GPX lines, sitting between the raw board pins and the Nios II as an Avalon-MM slave with one IRQ. It synchronizes both lines and captures INT assertions and GPX rising edges into sticky, write-1-to-clear flags. It gates the flags through a mask to drive `irq`. A stuck-INT watchdog flags an interrupt left unserviced for a programmable number of cycles.

## Interface
- `TMO_RESET`, 16'hFFFF, reset value of the watchdog timeout register
- `INT_ACTIVE_LOW`, 1, 1 means `usb_int` asserts low (MAX3421E default)
- `clk` in 1: system clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-high reset
- `address` in 2: register select
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe, qualified by `chipselect`
- `writedata` in 32: write data
- `usb_int` in 1: raw MAX3421E INT pin, asynchronous
- `usb_gpx` in 1: raw MAX3421E GPX pin, asynchronous
- `readdata` out 32: registered read data
- `irq` out 1: active-high level interrupt to the CPU

## Operation
- Both pins pass through 2-FF synchronizers. `int_lvl` is the synchronized INT normalized to active-high via `INT_ACTIVE_LOW`. `gpx_lvl` is the synchronized GPX.
- Register map (unused bits read 0):
  - addr 0 STATUS, RO: bit0 `int_lvl`, bit1 `gpx_lvl`, bits[3:2] FSM state.
  - addr 1 MASK, RW: bits[2:0].
  - addr 2 EVENT, read / write-1-to-clear: bit0 INT event, bit1 GPX rising edge, bit2 watchdog timeout.
  - addr 3 TMO, RW: bits[15:0], timeout in clk cycles; 0 disables the watchdog.
- `irq` = OR of (EVENT & MASK), registered.
- INT FSM, encoded IDLE=0, PEND=1, STUCK=2:
  - IDLE: on `int_lvl` rising edge, set EVENT[0], clear the counter, go to PEND.
  - PEND: counter increments each cycle.
    - Counter == TMO with TMO≠0: set EVENT[2], go to STUCK.
    - A write clearing EVENT[0]:
      - if `int_lvl`=0, go to IDLE;
      - if `int_lvl`=1 (level retrigger), EVENT[0] re-sets one cycle later, the counter clears, and the state stays PEND.
  - STUCK: counter holds. A clear of EVENT[0] follows the same rule as PEND. Clearing EVENT[2] alone has no state effect.
  - `int_lvl` falling in PEND or STUCK changes no state; only a software clear leaves PEND/STUCK.
- GPX: EVENT[1] sets on a `gpx_lvl` rising edge. It has no FSM.
- Arithmetic: the counter is 16-bit and saturates at 16'hFFFF. The compare is equality against the TMO value current in that cycle. Lowering TMO below the current count prevents a timeout until the next reload.

## Timing
- Reset values: `readdata`=0, `irq`=0, MASK=0, EVENT=0, TMO=`TMO_RESET`, FSM=IDLE, counter=0, synchronizer flops=inactive level.
- Pin to flag: EVENT bit set 3 clk after the pin edge (2 sync + 1 edge/capture). `irq` rises 1 clk after the EVENT bit if unmasked.
- Reads: `readdata` updates on the clk after `chipselect`, i.e. 1-cycle read latency. It holds its value when not selected. Reads have no side effects.
- Writes take effect at the clk edge where `chipselect`=1 and `write_n`=0.
- Simultaneous set and W1C clear of the same EVENT bit: the set wins.
- Simultaneous timeout and EVENT[0] clear: the clear wins, and EVENT[2] is not set.
- A MASK write affects `irq` on the following cycle.
- `reset` asserted mid-operation immediately forces all reset values, including `irq`=0. Edges occurring during reset are lost.

## Structure
- Shared package `crossy_robbers_usb_pkg` holds:
  - address constants ADDR_STATUS, ADDR_MASK, ADDR_EVENT, ADDR_TMO;
  - EVENT bit indices EV_INT, EV_GPX, EV_TMO;
  - the FSM state typedef;
  - the counter width constant (16).
- One sub-module, `crossy_robbers_sync_edge`, instantiated once per pin: a 2-FF synchronizer plus a rising-edge pulse output, with an async active-high reset value parameter.

## Test plan
- Reset, then read all four addresses → 0, 0, 0, 16'hFFFF; `irq`=0.
- MASK=3'b010; pulse `usb_gpx` high for 5 cycles → EVENT=3'b010 three clk after the edge, `irq`=1 on the next clk; write EVENT=3'b010 → EVENT=0 and `irq`=0 one clk later.
- TMO=10, MASK=3'b101; drive `usb_int` low and hold → EVENT[0]=1, STATUS[3:2]=1, then EVENT[2]=1 and state=2 ten cycles after entering PEND.
  - Write EVENT=3'b001 with INT still low → EVENT[0] re-sets next cycle, state=1.
  - Release INT and clear again → state=0.
- Issue an EVENT[1] W1C write in the same cycle as a GPX captured edge → EVENT[1] remains 1.
- TMO=0, hold INT asserted 70000 cycles → EVENT[2] stays 0; counter saturates with no wrap.
- Assert `reset` while in STUCK with `irq`=1 → `irq`=0 and all registers return to reset values without waiting for a clk edge.
